// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: read ports, writeback port, issue port, flush and busy vector.
// master = datapath driving addresses/strobes, slave = register file.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int unsigned NREGS = 1 << ADDR_W;

   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;
   logic              flush;
   logic [NREGS-1:0]  busy_vec;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write port,
// optional hardwired-zero r0 and a per-register pending-write (busy) scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding on reads.
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   regfile_scoreboard_if.slave  bus
);
   localparam int unsigned NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy;
   logic [NREGS-1:0]  busy_next;
   logic              wr_ok;
   logic [DATA_W-1:0] data1, data2;
   logic              bsy1, bsy2;

   // Writes to r0 are dropped when it is the hardwired-zero register.
   assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

   // Register array: async clear, write on rising edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Busy next-state: issue beats flush beats writeback; r0 never busy under ZERO_REG.
   always_comb begin
      busy_next = busy;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (bus.iss_en && (bus.iss_addr == ADDR_W'(i)))
            busy_next[i] = 1'b1;
         else if (bus.flush)
            busy_next[i] = 1'b0;
         else if (bus.wr_en && (bus.wr_addr == ADDR_W'(i)))
            busy_next[i] = 1'b0;
      end
      if (ZERO_REG != 0) busy_next[0] = 1'b0;
   end

   // Busy flops: async clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_next;
   end

   // Read ports: array/busy lookup, optional forwarding of the in-flight write, then zero-reg override.
   always_comb begin
      data1 = regs[bus.rd_addr1];
      data2 = regs[bus.rd_addr2];
      bsy1  = busy[bus.rd_addr1];
      bsy2  = busy[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.wr_addr == bus.rd_addr1)) begin
         data1 = bus.wr_data;
         bsy1  = bus.iss_en && (bus.iss_addr == bus.rd_addr1);
      end
      if (wr_ok && (bus.wr_addr == bus.rd_addr2)) begin
         data2 = bus.wr_data;
         bsy2  = bus.iss_en && (bus.iss_addr == bus.rd_addr2);
      end
`endif
      if ((ZERO_REG != 0) && (bus.rd_addr1 == '0)) begin
         data1 = '0;
         bsy1  = 1'b0;
      end
      if ((ZERO_REG != 0) && (bus.rd_addr2 == '0)) begin
         data2 = '0;
         bsy2  = 1'b0;
      end
   end

   assign bus.rd_data1 = data1;
   assign bus.rd_data2 = data2;
   assign bus.rd_busy1 = bsy1;
   assign bus.rd_busy2 = bsy2;
   assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 32x32 zero-reg instance plus a
// 16-bit, 8-entry, ZERO_REG=0 instance. Expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
   logic clock;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) b32 ();
   regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) b16 ();

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) d32 (
      .clock (clock), .reset (reset), .bus (b32)
   );
   regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) d16 (
      .clock (clock), .reset (reset), .bus (b16)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle32();
      b32.wr_en = 1'b0; b32.iss_en = 1'b0; b32.flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      b32.rd_addr1 = '0; b32.rd_addr2 = '0; b32.wr_en = 1'b0; b32.wr_addr = '0;
      b32.wr_data = '0; b32.iss_en = 1'b0; b32.iss_addr = '0; b32.flush = 1'b0;
      b16.rd_addr1 = '0; b16.rd_addr2 = '0; b16.wr_en = 1'b0; b16.wr_addr = '0;
      b16.wr_data = '0; b16.iss_en = 1'b0; b16.iss_addr = '0; b16.flush = 1'b0;
      #12;
      reset = 1'b0;

      // reset state
      chk("rst_data1", b32.rd_data1, 0);
      chk("rst_busy1", b32.rd_busy1, 0);
      chk("rst_vec",   b32.busy_vec, 0);

      // async reset: r5 written, r7 issued, then reset between edges
      b32.wr_en = 1'b1; b32.wr_addr = 5'd5; b32.wr_data = 32'hDEADBEEF;
      b32.iss_en = 1'b1; b32.iss_addr = 5'd7;
      tick();
      idle32();
      b32.rd_addr1 = 5'd5;
      #1;
      chk("pre_rst_r5",  b32.rd_data1, 32'hDEADBEEF);
      chk("pre_rst_vec", b32.busy_vec, 32'h0000_0080);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_r5",  b32.rd_data1, 0);
      chk("async_rst_vec", b32.busy_vec, 0);
      #1 reset = 1'b0;

      // zero register ignores write and issue
      tick();
      b32.wr_en = 1'b1; b32.wr_addr = 5'd0; b32.wr_data = 32'h12345678;
      b32.iss_en = 1'b1; b32.iss_addr = 5'd0; b32.rd_addr1 = 5'd0;
      #1;
      chk("r0_same_cycle", b32.rd_data1, 0);
      tick();
      idle32();
      #1;
      chk("r0_data",  b32.rd_data1, 0);
      chk("r0_busy",  b32.rd_busy1, 0);
      chk("r0_vec0",  b32.busy_vec[0], 0);

      // scoreboard: issue r9 at cycle 0, writeback at cycle 3
      b32.iss_en = 1'b1; b32.iss_addr = 5'd9; b32.rd_addr1 = 5'd9;
      #1;
      chk("r9_busy_c0", b32.rd_busy1, 0);
      tick();
      idle32();
      chk("r9_busy_c1", b32.rd_busy1, 1);
      tick();
      chk("r9_busy_c2", b32.rd_busy1, 1);
      tick();
      b32.wr_en = 1'b1; b32.wr_addr = 5'd9; b32.wr_data = 32'h0000_00AA;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("r9_busy_c3", b32.rd_busy1, 0);
      chk("r9_data_c3", b32.rd_data1, 32'hAA);
`else
      chk("r9_busy_c3", b32.rd_busy1, 1);
      chk("r9_data_c3", b32.rd_data1, 0);
`endif
      tick();
      idle32();
      chk("r9_busy_c4", b32.rd_busy1, 0);
      chk("r9_data_c4", b32.rd_data1, 32'hAA);
      chk("r9_vec_c4",  b32.busy_vec, 0);

      // writeback to non-busy register: data lands, busy stays 0
      b32.wr_en = 1'b1; b32.wr_addr = 5'd12; b32.wr_data = 32'hC0FFEE00;
      b32.rd_addr2 = 5'd12;
      tick();
      idle32();
      chk("r12_data", b32.rd_data2, 32'hC0FFEE00);
      chk("r12_busy", b32.rd_busy2, 0);
      chk("r12_vec",  b32.busy_vec, 0);

      // collision: r4 busy, then writeback and re-issue r4 together
      b32.iss_en = 1'b1; b32.iss_addr = 5'd4;
      tick();
      idle32();
      chk("r4_vec_busy", b32.busy_vec, 32'h10);
      b32.wr_en = 1'b1; b32.wr_addr = 5'd4; b32.wr_data = 32'h55;
      b32.iss_en = 1'b1; b32.iss_addr = 5'd4; b32.rd_addr2 = 5'd4;
      #1;
      chk("r4_coll_busy_same", b32.rd_busy2, 1);
`ifdef REGFILE_BYPASS_EN
      chk("r4_coll_data_same", b32.rd_data2, 32'h55);
`else
      chk("r4_coll_data_same", b32.rd_data2, 0);
`endif
      tick();
      idle32();
      chk("r4_coll_data", b32.rd_data2, 32'h55);
      chk("r4_coll_vec",  b32.busy_vec, 32'h10);

      // flush with issue: r2, r3 (and r4) busy, flush + issue r6 leaves only r6
      b32.iss_en = 1'b1; b32.iss_addr = 5'd2;
      tick();
      b32.iss_addr = 5'd3;
      tick();
      idle32();
      chk("pre_flush_vec", b32.busy_vec, 32'h1C);
      b32.flush = 1'b1; b32.iss_en = 1'b1; b32.iss_addr = 5'd6;
      tick();
      idle32();
      chk("flush_vec", b32.busy_vec, 32'h40);
      chk("flush_r4_data", b32.rd_data2, 32'h55);

      // repeated issue to busy r6, then one writeback clears it
      b32.iss_en = 1'b1; b32.iss_addr = 5'd6;
      tick();
      idle32();
      chk("reissue_vec", b32.busy_vec, 32'h40);
      b32.wr_en = 1'b1; b32.wr_addr = 5'd6; b32.wr_data = 32'h66;
      tick();
      idle32();
      chk("reissue_clr_vec", b32.busy_vec, 0);

      // same-cycle read-after-write on both ports
      b32.wr_en = 1'b1; b32.wr_addr = 5'd10; b32.wr_data = 32'h1;
      tick();
      b32.wr_data = 32'h2; b32.rd_addr1 = 5'd10; b32.rd_addr2 = 5'd10;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("raw_p1_same", b32.rd_data1, 32'h2);
      chk("raw_p2_same", b32.rd_data2, 32'h2);
`else
      chk("raw_p1_same", b32.rd_data1, 32'h1);
      chk("raw_p2_same", b32.rd_data2, 32'h1);
`endif
      tick();
      idle32();
      chk("raw_p1_next", b32.rd_data1, 32'h2);
      chk("raw_p2_next", b32.rd_data2, 32'h2);

      // 16-bit, 8-entry instance without zero register
      b16.wr_en = 1'b1; b16.wr_data = 16'hBEEF;
      for (int i = 0; i < 8; i++) begin
         b16.wr_addr = 3'(i);
         tick();
      end
      b16.wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b16.rd_addr1 = 3'(i);
         b16.rd_addr2 = 3'(7 - i);
         #1;
         chk($sformatf("w16_p1_r%0d", i), b16.rd_data1, 16'hBEEF);
         chk($sformatf("w16_p2_r%0d", 7 - i), b16.rd_data2, 16'hBEEF);
      end
      b16.wr_en = 1'b1; b16.wr_addr = 3'd3; b16.wr_data = 16'h1234;
      tick();
      b16.wr_en = 1'b0; b16.rd_addr1 = 3'd3; b16.rd_addr2 = 3'd2;
      #1;
      chk("w16_r3_new", b16.rd_data1, 16'h1234);
      chk("w16_r2_keep", b16.rd_data2, 16'hBEEF);
      b16.iss_en = 1'b1; b16.iss_addr = 3'd0; b16.rd_addr1 = 3'd0;
      tick();
      b16.iss_en = 1'b0;
      chk("w16_r0_busy", b16.rd_busy1, 1);
      chk("w16_r0_vec",  b16.busy_vec, 8'h01);
      chk("w16_r0_data", b16.rd_data1, 16'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
